rr_arbiter4: RTL
================

Name: rr_arbiter4

Overview:
- Round-robin arbiter granting one shared resource to four requesters.
- Requests arrive as a 4-bit vector. The grant is issued both one-hot and binary-encoded, so downstream muxes can select the owner directly.
- A hold-timeout keeps any one requester from monopolising the resource.
- The block sits in front of any 4-way shared datapath (bus, memory port, ALU) and sequences ownership of it.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one grant may be held. 0 disables the timeout. Legal range is 0..255.
- CW, 8: width of the hold counter. It must satisfy 2^CW > MAX_HOLD.

Ports:
- clk: input, 1 bit. Single clock; all state updates on its rising edge.
- reset_n: input, 1 bit. Asynchronous, active-low reset.
- req: input, 4 bits. Request per requester. A requester holds its bit high for as long as it wants the resource.
- gnt: output, 4 bits. Registered one-hot grant; 4'b0000 when idle.
- gnt_idx: output, 2 bits. Registered binary index of the current owner; 2'b00 when idle.
- busy: output, 1 bit. High while any grant is active. Equal to |gnt.
- timeout: output, 1 bit. One-cycle pulse, asserted in the cycle after a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (async assert, synchronous-to-clk deassert by the system) sets:
  - state=IDLE, gnt=0, gnt_idx=0, busy=0, timeout=0;
  - priority pointer ptr=0, so requester 0 has highest priority;
  - hold_cnt=0.
- Reset asserted mid-grant drops gnt immediately. No timeout pulse is issued.
- State IDLE:
  - If req != 0 at a rising edge, pick the winner: the first set bit searching ptr, ptr+1, ptr+2, ptr+3, wrapping mod 4.
  - Then set gnt=onehot(winner), gnt_idx=winner, hold_cnt=0, ptr=winner+1 mod 4, and go to GRANT.
  - Latency: req visible before edge k gives gnt valid after edge k (1 cycle).
- State GRANT:
  - Each edge, if req[gnt_idx]=0 (owner released): gnt=0, gnt_idx=0, go to IDLE.
  - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: gnt=0, gnt_idx=0, timeout=1 for the next cycle, go to IDLE.
  - Else hold_cnt increments.
  - Release takes priority over timeout when both apply on the same edge; no timeout pulse in that case.
- Turnaround: every grant is followed by at least one IDLE cycle with gnt=0, giving guaranteed break-before-make between owners.
- Requests from non-owners during GRANT are ignored. They are evaluated at the next IDLE edge.
- A requester revoked by timeout keeps its req high and re-competes. Because ptr already advanced past it, it has the lowest priority among active requests.
- With a single continuous requester and MAX_HOLD=M, gnt follows the pattern: M cycles high, 1 low, repeating.
- All four requesting continuously: grants rotate 0,1,2,3,0,... with each owner served once per four grants.
- Width rules:
  - ptr arithmetic is 2-bit and wraps naturally (3+1 -> 0).
  - hold_cnt is CW bits and never exceeds MAX_HOLD-1.
- Outputs gnt, gnt_idx, busy and timeout are all driven from flops; no combinational path from req to any output.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=1'b0, GRANT=1'b1;
  - NREQ=4;
  - index width IW=2.
- One natural combinational sub-module, rr_pick4:
  - inputs req[3:0] and ptr[1:0];
  - outputs win_idx[1:0] and any_req.
  - It contains the rotate, priority-encode and un-rotate logic.
  - The top level registers its result and owns the FSM, hold counter and pointer.

Test Plan:
- Reset, then req=4'b0100 held: gnt=4'b0100, gnt_idx=2 one cycle after the req edge. Drop req, and gnt=0 at the next edge. ptr is now 3.
- After reset, req=4'b1111 held, MAX_HOLD=0: all four owners complete without timeout. The owner drops req after 2 granted cycles; the grant sequence is idx 0,1,2,3,0 with exactly one gnt=0 cycle between each grant.
- MAX_HOLD=8, req=4'b0001 held forever: gnt high 8 cycles, low 1 cycle with timeout=1 in that cycle, then re-granted. Pattern repeats and timeout never asserts during grant.
- MAX_HOLD=3, req=4'b0011 held: order idx 0 (timeout), 1 (timeout), 0, 1, ... Each grant lasts 3 cycles.
- Owner drops req on the same edge hold_cnt==MAX_HOLD-1: gnt drops and timeout stays 0.
- Assert reset_n=0 mid-grant with gnt=4'b0010: gnt=0, gnt_idx=0 and busy=0 immediately without waiting for clk. After release, with req=4'b0010, the grant goes to idx 1 since ptr=0 and req[0]=0.

Source files
------------

// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-way round-robin arbiter.
package rr_arbiter4_pkg;

  localparam int NREQ = 4;
  localparam int IW   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Binary requester index to one-hot grant vector.
  function automatic logic [NREQ-1:0] idx2onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter4_pick.sv
// Combinational round-robin winner selection: rotate the request vector so
// that the pointer position lands at bit 0, take the lowest set bit, then
// add the pointer back to recover the absolute requester index.
module rr_pick4
  import rr_arbiter4_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   win_idx,
  output logic            any_req
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [IW-1:0]     rot_off;

  // Rotate requests so that requester 'ptr' sits at bit 0.
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[ptr +: NREQ];
  end

  // Lowest set bit of the rotated vector has the highest priority.
  always_comb begin
    rot_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) rot_off = IW'(i);
    end
  end

  // Un-rotate; the 2-bit add wraps modulo four on its own.
  always_comb begin
    win_idx = ptr + rot_off;
    any_req = |req;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with registered one-hot/binary grant, a
// mandatory idle cycle between owners and an optional hold timeout.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            busy,
  output logic            timeout
);

  // Hold count at which the grant is revoked; only meaningful when enabled.
  localparam logic          TO_EN     = (MAX_HOLD != 0);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_e          state_q,   state_d;
  logic [NREQ-1:0] gnt_q,     gnt_d;
  logic [IW-1:0]   idx_q,     idx_d;
  logic [IW-1:0]   ptr_q,     ptr_d;
  logic [CW-1:0]   hold_q,    hold_d;
  logic            busy_q,    busy_d;
  logic            timeout_q, timeout_d;

  logic [IW-1:0]   win_idx;
  logic            any_req;

  rr_pick4 u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  // State, grant, pointer and hold-counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, watch release/timeout in GRANT.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          gnt_d   = idx2onehot(win_idx);
          idx_d   = win_idx;
          ptr_d   = win_idx + IW'(1);
          hold_d  = '0;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          // Owner release wins over a coincident timeout: no pulse.
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b0;
        end else if (TO_EN && (hold_q == HOLD_LAST)) begin
          state_d   = IDLE;
          gnt_d     = '0;
          idx_d     = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All outputs come straight from flops.
  always_comb begin
    gnt     = gnt_q;
    gnt_idx = idx_q;
    busy    = busy_q;
    timeout = timeout_q;
  end

endmodule
